// File: rtl/rdma_stream_pkg.sv
// Shared definitions for the RDMA/video stream blocks (segmenter and reassembler).
// Holds the default widths, the slot helper functions and the default keep-mask type.
package rdma_stream_pkg;

  localparam int unsigned DefaultMtu       = 64;
  localparam int unsigned DefaultFrameSize = 128;

  function automatic int unsigned frame_ratio(input int unsigned mtu,
                                              input int unsigned frame_size);
    return frame_size / mtu;
  endfunction

  // Slot 0 occupies the most significant segment of the frame.
  function automatic int unsigned slot_msb(input int unsigned k,
                                           input int unsigned mtu,
                                           input int unsigned frame_size);
    return frame_size - 1 - k * mtu;
  endfunction

  localparam int unsigned DefaultRatio = frame_ratio(DefaultMtu, DefaultFrameSize);

  typedef logic [DefaultRatio-1:0] keep_t;

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-Stream holding register: loads a beat when empty or draining,
// holds it stable while the consumer stalls.
module axis_out_reg #(
  parameter int unsigned DataW = 128,
  parameter int unsigned KeepW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [DataW-1:0] data_i,
  input  logic [KeepW-1:0] keep_i,
  input  logic             last_i,
  output logic             in_ready_o,
  output logic             valid_o,
  output logic [DataW-1:0] data_o,
  output logic [KeepW-1:0] keep_o,
  output logic             last_o,
  input  logic             ready_i
);

  logic             valid_q;
  logic [DataW-1:0] data_q;
  logic [KeepW-1:0] keep_q;
  logic             last_q;

  assign in_ready_o = !valid_q || ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i && in_ready_o) begin
      // A load in the same cycle as a handoff keeps valid asserted.
      valid_q <= 1'b1;
      data_q  <= data_i;
      keep_q  <= keep_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign last_o  = last_q;

endmodule

// File: rtl/packet_reassembler.sv
// Packs MTU-wide input segments MSB-first into AXI_FRAME_SIZE-wide frames;
// tlast flushes a short frame with a per-slot keep mask.
module packet_reassembler
  import rdma_stream_pkg::*;
#(
  parameter int unsigned MTU            = DefaultMtu,
  parameter int unsigned AXI_FRAME_SIZE = DefaultFrameSize
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MTU-1:0]                s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [AXI_FRAME_SIZE-1:0]     m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [AXI_FRAME_SIZE/MTU-1:0] m_axis_tkeep,
  input  logic                          m_axis_tready
);

  localparam int unsigned RATIO = frame_ratio(MTU, AXI_FRAME_SIZE);

  if ((AXI_FRAME_SIZE % MTU) != 0 || MTU > AXI_FRAME_SIZE) begin : g_param_err
    $error("packet_reassembler: AXI_FRAME_SIZE must be a whole multiple of MTU");
  end

  if (RATIO == 1) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk, rst};

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = s_axis_tvalid;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tkeep  = 1'b1;
    assign s_axis_tready = m_axis_tready;
  end else begin : g_pack
    localparam int unsigned CntW = $clog2(RATIO);

    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [AXI_FRAME_SIZE-1:0] acc_q, acc_d, merged;
    logic [RATIO-1:0]          acc_keep_q, acc_keep_d, merged_keep;
    logic                      out_ready;
    logic                      accept;
    logic                      last_slot;
    logic                      complete;

    assign s_axis_tready = out_ready;
    assign accept        = s_axis_tvalid && out_ready;
    assign last_slot     = (cnt_q == CntW'(RATIO - 1));
    assign complete      = accept && (last_slot || s_axis_tlast);

    // Accumulator with the incoming segment dropped into the current slot.
    always_comb begin
      merged      = acc_q;
      merged_keep = acc_keep_q;
      for (int unsigned k = 0; k < RATIO; k++) begin
        if (cnt_q == CntW'(k)) begin
          merged[slot_msb(k, MTU, AXI_FRAME_SIZE) -: MTU] = s_axis_tdata;
          merged_keep[RATIO-1-k]                          = 1'b1;
        end
      end
    end

    always_comb begin
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      acc_keep_d = acc_keep_q;
      if (complete) begin
        cnt_d      = '0;
        acc_d      = '0;
        acc_keep_d = '0;
      end else if (accept) begin
        cnt_d      = cnt_q + CntW'(1);
        acc_d      = merged;
        acc_keep_d = merged_keep;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q      <= '0;
        acc_q      <= '0;
        acc_keep_q <= '0;
      end else begin
        cnt_q      <= cnt_d;
        acc_q      <= acc_d;
        acc_keep_q <= acc_keep_d;
      end
    end

    axis_out_reg #(
      .DataW (AXI_FRAME_SIZE),
      .KeepW (RATIO)
    ) u_out_reg (
      .clk        (clk),
      .rst        (rst),
      .load_i     (complete),
      .data_i     (merged),
      .keep_i     (merged_keep),
      .last_i     (s_axis_tlast),
      .in_ready_o (out_ready),
      .valid_o    (m_axis_tvalid),
      .data_o     (m_axis_tdata),
      .keep_o     (m_axis_tkeep),
      .last_o     (m_axis_tlast),
      .ready_i    (m_axis_tready)
    );
  end

endmodule

// File: tb/tb_packet_reassembler.sv
// Bench for packet_reassembler: directed vector table, multi-cycle corner sequences,
// randomized traffic against a queue-based frame model, and a bypass instance.
module tb_packet_reassembler;
  import rdma_stream_pkg::*;

  localparam int unsigned Ratio = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  s_tdata  = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tlast  = 1'b0;
  logic         s_tready;
  logic [127:0] m_tdata;
  logic         m_tvalid;
  logic         m_tlast;
  keep_t        m_tkeep;
  logic         m_tready = 1'b1;

  logic [127:0] b_s_tdata  = '0;
  logic         b_s_tvalid = 1'b0;
  logic         b_s_tlast  = 1'b0;
  logic         b_s_tready;
  logic [127:0] b_m_tdata;
  logic         b_m_tvalid;
  logic         b_m_tlast;
  logic [0:0]   b_m_tkeep;
  logic         b_m_tready = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  packet_reassembler dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tready (m_tready)
  );

  packet_reassembler #(
    .MTU            (128),
    .AXI_FRAME_SIZE (128)
  ) dut_bypass (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (b_s_tdata),
    .s_axis_tvalid (b_s_tvalid),
    .s_axis_tlast  (b_s_tlast),
    .s_axis_tready (b_s_tready),
    .m_axis_tdata  (b_m_tdata),
    .m_axis_tvalid (b_m_tvalid),
    .m_axis_tlast  (b_m_tlast),
    .m_axis_tkeep  (b_m_tkeep),
    .m_axis_tready (b_m_tready)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] seg_of(input int c);
    logic [7:0] b;
    b = 8'(c) + 8'h10;
    return {8{b}};
  endfunction

  typedef struct {
    logic [63:0]  seg0;
    logic [63:0]  seg1;
    int           nseg;
    logic         last;
    logic [127:0] exp_data;
    logic [1:0]   exp_keep;
  } vec_t;

  typedef struct packed {
    logic [127:0] data;
    logic [1:0]   keep;
    logic         last;
  } frame_t;

  vec_t        vecs[4];
  frame_t      exp_q[$];
  logic [63:0] cur_q[$];

  // Model: a frame is the accepted segments placed left to right, zero-padded on the right.
  function automatic frame_t build_frame(input logic last);
    frame_t f;
    int     n;
    n      = cur_q.size();
    f.data = '0;
    foreach (cur_q[i]) f.data = (f.data << 64) | 128'(cur_q[i]);
    f.data = f.data << (64 * (Ratio - n));
    f.keep = 2'(((1 << n) - 1) << (Ratio - n));
    f.last = last;
    return f;
  endfunction

  initial begin
    frame_t      f;
    logic [63:0] sa, sb, sc, sd;
    logic        exp_b;

    vecs[0] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 2, 1'b1,
                {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222}, 2'b11};
    vecs[1] = '{64'h0000_0000_0000_CAFE, 64'h0, 1, 1'b1,
                {64'h0000_0000_0000_CAFE, 64'h0}, 2'b10};
    vecs[2] = '{64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF, 2, 1'b0,
                {64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF}, 2'b11};
    vecs[3] = '{64'hFFFF_0000_FFFF_0000, 64'h0, 1, 1'b1,
                {64'hFFFF_0000_FFFF_0000, 64'h0}, 2'b10};

    // Reset state
    #3;
    chk("rst_m_valid", m_tvalid, 0);
    chk("rst_m_data", m_tdata, 0);
    chk("rst_m_keep", m_tkeep, 0);
    chk("rst_m_last", m_tlast, 0);
    #9 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", s_tready, 1);

    // Directed vector table, m_ready held high
    m_tready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      for (int s = 0; s < vecs[v].nseg; s++) begin
        @(posedge clk); #1;
        s_tvalid = 1'b1;
        s_tdata  = (s == 0) ? vecs[v].seg0 : vecs[v].seg1;
        s_tlast  = (s == vecs[v].nseg - 1) ? vecs[v].last : 1'b0;
      end
      @(posedge clk); #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", v), m_tvalid, 1);
      chk($sformatf("vec%0d_data", v), m_tdata, vecs[v].exp_data);
      chk($sformatf("vec%0d_keep", v), m_tkeep, vecs[v].exp_keep);
      chk($sformatf("vec%0d_last", v), m_tlast, vecs[v].last);
      @(negedge clk);
      chk($sformatf("vec%0d_one_cycle", v), m_tvalid, 0);
    end

    // Eight back-to-back segments: one frame every two cycles, tlast on the fourth only
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      s_tvalid = (c < 8);
      s_tdata  = seg_of(c);
      s_tlast  = (c == 7);
      @(negedge clk);
      chk($sformatf("b2b%0d_s_ready", c), s_tready, 1);
      exp_b = (c >= 2) && (c % 2 == 0) && (c <= 8);
      chk($sformatf("b2b%0d_valid", c), m_tvalid, exp_b);
      if (exp_b) begin
        chk($sformatf("b2b%0d_data", c), m_tdata, {seg_of(c - 2), seg_of(c - 1)});
        chk($sformatf("b2b%0d_keep", c), m_tkeep, 2'b11);
        chk($sformatf("b2b%0d_last", c), m_tlast, (c == 8));
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;

    // Stall: frame held stable, input blocked, then one-cycle handoff with slot-0 capture
    sa = 64'hA0A0_0000_0000_0001;
    sb = 64'hB0B0_0000_0000_0002;
    sc = 64'hC0C0_0000_0000_0003;
    sd = 64'hD0D0_0000_0000_0004;
    @(posedge clk); #1;
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = sa;
    @(posedge clk); #1;
    s_tdata = sb;
    @(posedge clk); #1;
    s_tdata = sc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", i), m_tvalid, 1);
      chk($sformatf("stall%0d_data", i), m_tdata, {sa, sb});
      chk($sformatf("stall%0d_keep", i), m_tkeep, 2'b11);
      chk($sformatf("stall%0d_last", i), m_tlast, 0);
      chk($sformatf("stall%0d_s_ready", i), s_tready, 0);
    end
    @(posedge clk); #1;
    m_tready = 1'b1;
    @(negedge clk);
    chk("stall_release_s_ready", s_tready, 1);
    @(posedge clk); #1;
    m_tready = 1'b0;
    s_tdata  = sd;
    s_tlast  = 1'b1;
    @(negedge clk);
    chk("stall_handoff_valid", m_tvalid, 0);
    chk("stall_handoff_s_ready", s_tready, 1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    chk("stall_next_valid", m_tvalid, 1);
    chk("stall_next_data", m_tdata, {sc, sd});
    chk("stall_next_keep", m_tkeep, 2'b11);
    chk("stall_next_last", m_tlast, 1);
    @(negedge clk);
    chk("stall_next_drop", m_tvalid, 0);

    // Asynchronous reset while a frame is held
    @(posedge clk); #1;
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = sa;
    @(posedge clk); #1;
    s_tdata = sb;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    #2;
    chk("arst_pre_valid", m_tvalid, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", m_tvalid, 0);
    chk("arst_data", m_tdata, 0);
    chk("arst_keep", m_tkeep, 0);
    #1 rst = 1'b0;

    // Asynchronous reset after a partial frame: stale segment must vanish
    m_tready = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b1;
    s_tdata  = 64'h5151_5151_5151_5151;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst2_valid", m_tvalid, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    s_tvalid = 1'b1;
    s_tdata  = 64'h7777_0000_0000_7777;
    @(posedge clk); #1;
    s_tdata = 64'h8888_0000_0000_8888;
    s_tlast = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    @(negedge clk);
    chk("arst2_xy_valid", m_tvalid, 1);
    chk("arst2_xy_data", m_tdata, {64'h7777_0000_0000_7777, 64'h8888_0000_0000_8888});
    chk("arst2_xy_keep", m_tkeep, 2'b11);
    chk("arst2_xy_last", m_tlast, 1);

    // Randomized traffic against the frame-queue model
    @(posedge clk); #1;
    rst = 1'b1;
    #2 rst = 1'b0;
    exp_q.delete();
    cur_q.delete();
    for (int c = 0; c < 620; c++) begin
      @(posedge clk); #1;
      if (c < 600) begin
        s_tvalid = ($urandom_range(0, 3) != 0);
        s_tdata  = {$urandom, $urandom};
        s_tlast  = ($urandom_range(0, 3) == 0);
        m_tready = ($urandom_range(0, 2) != 0);
      end else begin
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
      end
      @(negedge clk);
      chk("rnd_valid", m_tvalid, (exp_q.size() != 0));
      chk("rnd_s_ready", s_tready, (exp_q.size() == 0) || m_tready);
      if (m_tvalid && exp_q.size() != 0) begin
        chk("rnd_data", m_tdata, exp_q[0].data);
        chk("rnd_keep", m_tkeep, exp_q[0].keep);
        chk("rnd_last", m_tlast, exp_q[0].last);
        if (m_tready) void'(exp_q.pop_front());
      end
      if (s_tvalid && s_tready) begin
        cur_q.push_back(s_tdata);
        if (cur_q.size() == Ratio || s_tlast) begin
          f = build_frame(s_tlast);
          exp_q.push_back(f);
          cur_q.delete();
        end
      end
    end
    chk("rnd_drained", exp_q.size(), 0);

    // Bypass instance is a pure combinational pass-through
    for (int i = 0; i < 8; i++) begin
      b_s_tdata  = {$urandom, $urandom, $urandom, $urandom};
      b_s_tvalid = i[0];
      b_s_tlast  = i[1];
      b_m_tready = i[2];
      #1;
      chk($sformatf("byp%0d_data", i), b_m_tdata, b_s_tdata);
      chk($sformatf("byp%0d_valid", i), b_m_tvalid, i[0]);
      chk($sformatf("byp%0d_last", i), b_m_tlast, i[1]);
      chk($sformatf("byp%0d_ready", i), b_s_tready, i[2]);
      chk($sformatf("byp%0d_keep", i), b_m_tkeep, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
